// File: rtl/idc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : idc_controller
//  Purpose  : Image display controller. Streams a 64-pixel 8x8 image out of
//             the image ROM into a local pixel array, applies host commands
//             that move or modify a 2x2 operation window, and dumps the whole
//             array to the image result buffer (IRB) on a write command.
//  Revision : 1.0  initial release
// ============================================================================
module idc_controller #(
  parameter int DW      = 8,  // pixel data width
  parameter int AW      = 6,  // pixel address width, row-major addr = y*8 + x
  parameter int OP_INIT = 4   // initial x and y of the operation point
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  output logic          IRB_RW,
  output logic [AW-1:0] IRB_A,
  output logic [DW-1:0] IRB_D,
  output logic          busy,
  output logic          done
);

  // Coordinate width: the image is square, so each axis takes half the address.
  localparam int CW   = AW / 2;
  localparam int NPIX = 1 << AW;

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_MAX  = CW'((1 << CW) - 1);
  localparam logic [CW-1:0] C_INIT = CW'(OP_INIT);
  localparam logic [AW:0]   C_CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] C_LAST = AW'(NPIX - 1);

  // Command codes
  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_AVG   = 3'd5;
  localparam logic [2:0] CMD_MIRX  = 3'd6;
  localparam logic [2:0] CMD_MIRY  = 3'd7;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q;

  // ROM side: issue counter (MSB set once all addresses are out), capture
  // pointer and a one-deep valid flag that delays the enable by one cycle so
  // captures land two edges after the matching address.
  logic [AW:0]   rd_cnt_q;
  logic [AW-1:0] cap_q;
  logic          rd_vld_q;

  // IRB side write counter (MSB set once all 64 pixels are out)
  logic [AW:0]   wr_cnt_q;

  // Operation point and latched command
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic [2:0]    cmd_q;

  // Registered outputs
  logic          irom_en_q;
  logic [AW-1:0] irom_a_q;
  logic          irb_rw_q;
  logic [AW-1:0] irb_a_q;
  logic [DW-1:0] irb_d_q;
  logic          busy_q;
  logic          done_q;

  // Pixel storage; contents after reset are don't-care, so it carries no reset.
  logic [DW-1:0] pix_q [NPIX];

  // Window addresses: P0 top-left, P1 top-right, P2 bottom-left, P3 bottom-right.
  logic [AW-1:0] p0_a;
  logic [AW-1:0] p1_a;
  logic [AW-1:0] p2_a;
  logic [AW-1:0] p3_a;
  logic [DW+1:0] win_sum;
  logic [DW-1:0] win_avg;

  assign p0_a = {y_q - C_ONE, x_q - C_ONE};
  assign p1_a = {y_q - C_ONE, x_q};
  assign p2_a = {y_q, x_q - C_ONE};
  assign p3_a = {y_q, x_q};

  // Two guard bits keep the four-pixel sum exact before the divide-by-four.
  assign win_sum = (DW + 2)'(pix_q[p0_a]) + (DW + 2)'(pix_q[p1_a])
                 + (DW + 2)'(pix_q[p2_a]) + (DW + 2)'(pix_q[p3_a]);
  assign win_avg = win_sum[DW+1:2];

  assign IROM_EN = irom_en_q;
  assign IROM_A  = irom_a_q;
  assign IRB_RW  = irb_rw_q;
  assign IRB_A   = irb_a_q;
  assign IRB_D   = irb_d_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Controller FSM: sequencing, operation point and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LOAD;
      rd_cnt_q  <= '0;
      cap_q     <= '0;
      rd_vld_q  <= 1'b0;
      wr_cnt_q  <= '0;
      x_q       <= C_INIT;
      y_q       <= C_INIT;
      cmd_q     <= CMD_WRITE;
      irom_en_q <= 1'b1;
      irom_a_q  <= '0;
      irb_rw_q  <= 1'b1;
      irb_a_q   <= '0;
      irb_d_q   <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          // Back-to-back address issue, one per cycle, then release the ROM.
          if (!rd_cnt_q[AW]) begin
            irom_en_q <= 1'b0;
            irom_a_q  <= rd_cnt_q[AW-1:0];
            rd_cnt_q  <= rd_cnt_q + C_CNT_ONE;
          end else begin
            irom_en_q <= 1'b1;
          end
          // Enable seen one cycle ago means data is valid at the next edge.
          rd_vld_q <= ~irom_en_q;
          if (rd_vld_q) begin
            cap_q <= cap_q + AW'(1);
            if (cap_q == C_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        S_IDLE: begin
          rd_vld_q <= 1'b0;
          if (cmd_valid) begin
            cmd_q    <= cmd;
            busy_q   <= 1'b1;
            wr_cnt_q <= '0;
            state_q  <= (cmd == CMD_WRITE) ? S_WRITE : S_EXEC;
          end
        end

        S_EXEC: begin
          // Shifts saturate at the window limits; a saturated shift still
          // spends its busy cycle here. Pixel edits happen in the array block.
          case (cmd_q)
            CMD_UP:    if (y_q > C_ONE) y_q <= y_q - C_ONE;
            CMD_DOWN:  if (y_q < C_MAX) y_q <= y_q + C_ONE;
            CMD_LEFT:  if (x_q > C_ONE) x_q <= x_q - C_ONE;
            CMD_RIGHT: if (x_q < C_MAX) x_q <= x_q + C_ONE;
            default: ;
          endcase
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        S_WRITE: begin
          // One IRB write per cycle, then a single closing cycle with done.
          if (!wr_cnt_q[AW]) begin
            irb_rw_q <= 1'b0;
            irb_a_q  <= wr_cnt_q[AW-1:0];
            irb_d_q  <= pix_q[wr_cnt_q[AW-1:0]];
            wr_cnt_q <= wr_cnt_q + C_CNT_ONE;
          end else begin
            irb_rw_q <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Pixel array updates: ROM capture during load, window edits during exec.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && rd_vld_q) begin
      pix_q[cap_q] <= IROM_Q;
    end else if (state_q == S_EXEC) begin
      case (cmd_q)
        CMD_AVG: begin
          pix_q[p0_a] <= win_avg;
          pix_q[p1_a] <= win_avg;
          pix_q[p2_a] <= win_avg;
          pix_q[p3_a] <= win_avg;
        end
        CMD_MIRX: begin
          pix_q[p0_a] <= pix_q[p2_a];
          pix_q[p2_a] <= pix_q[p0_a];
          pix_q[p1_a] <= pix_q[p3_a];
          pix_q[p3_a] <= pix_q[p1_a];
        end
        CMD_MIRY: begin
          pix_q[p0_a] <= pix_q[p1_a];
          pix_q[p1_a] <= pix_q[p0_a];
          pix_q[p2_a] <= pix_q[p3_a];
          pix_q[p3_a] <= pix_q[p2_a];
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idc_controller
//  Purpose  : Self-checking bench for idc_controller with an image ROM model
//             and a coordinate/array reference model of the command set.
//  Revision : 1.0  initial release
// ============================================================================
module tb_idc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic       cmd_valid = 1'b0;
  logic [7:0] IROM_Q;
  logic       IROM_EN;
  logic [5:0] IROM_A;
  logic       IRB_RW;
  logic [5:0] IRB_A;
  logic [7:0] IRB_D;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  idc_controller #(.DW(8), .AW(6), .OP_INIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .IROM_Q    (IROM_Q),
    .IROM_EN   (IROM_EN),
    .IROM_A    (IROM_A),
    .IRB_RW    (IRB_RW),
    .IRB_A     (IRB_A),
    .IRB_D     (IRB_D),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // ROM: address latched on a negedge with EN low, data out on the next negedge.
  logic [7:0] mem [64];
  logic [5:0] rom_lat_a;
  logic       rom_lat_v = 1'b0;
  always @(negedge clk) begin
    if (rom_lat_v) IROM_Q <= mem[rom_lat_a];
    rom_lat_v <= !IROM_EN;
    rom_lat_a <= IROM_A;
  end

  // Reference model: operation point and image contents.
  int         mx, my;
  logic [7:0] model [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_model(input int c);
    int a0, a1, a2, a3, s;
    logic [7:0] t;
    a0 = (my - 1) * 8 + (mx - 1);
    a1 = a0 + 1;
    a2 = a0 + 8;
    a3 = a2 + 1;
    case (c)
      1: if (my > 1) my--;
      2: if (my < 7) my++;
      3: if (mx > 1) mx--;
      4: if (mx < 7) mx++;
      5: begin
        s = int'(model[a0]) + int'(model[a1]) + int'(model[a2]) + int'(model[a3]);
        model[a0] = 8'(s / 4); model[a1] = 8'(s / 4);
        model[a2] = 8'(s / 4); model[a3] = 8'(s / 4);
      end
      6: begin
        t = model[a0]; model[a0] = model[a2]; model[a2] = t;
        t = model[a1]; model[a1] = model[a3]; model[a3] = t;
      end
      7: begin
        t = model[a0]; model[a0] = model[a1]; model[a1] = t;
        t = model[a2]; model[a2] = model[a3]; model[a3] = t;
      end
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Checks the 66-cycle load sequence starting at the first edge after release.
  task automatic load_check();
    int errs = 0;
    int first = -1;
    for (int n = 0; n < 66; n++) begin
      step();
      if (n < 64) begin
        if (IROM_EN !== 1'b0 || IROM_A !== 6'(n)) begin errs++; if (first < 0) first = n; end
      end else if (IROM_EN !== 1'b1) begin
        errs++; if (first < 0) first = n;
      end
      if (busy !== ((n < 65) ? 1'b1 : 1'b0)) begin errs++; if (first < 0) first = n; end
    end
    chk($sformatf("load_seq(first bad cycle %0d)", first), 32'(errs), 32'd0);
    chk("load_busy_low", 32'(busy), 32'd0);
    for (int i = 0; i < 64; i++) model[i] = mem[i];
    mx = 4;
    my = 4;
  endtask

  task automatic reset_and_load(input bit rnd);
    reset = 1'b1;
    cmd_valid = 1'b0;
    #1;
    chk("reset_values", 32'({IROM_EN, IROM_A, IRB_RW, IRB_A, IRB_D, busy, done}),
        32'({1'b1, 6'd0, 1'b1, 6'd0, 8'd0, 1'b1, 1'b0}));
    if (rnd) for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
    step();
    step();
    reset = 1'b0;
    load_check();
  endtask

  // Follows the 64 IRB writes after the accept edge; optional strobes are noise.
  task automatic do_write(input bit strobe);
    int errs = 0;
    int first = -1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (strobe) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd = 3'($urandom_range(0, 7));
      end
      if (IRB_RW !== 1'b0 || IRB_A !== 6'(i) || IRB_D !== model[i]) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    cmd_valid = 1'b0;
    chk($sformatf("write_seq(first bad addr %0d)", first), 32'(errs), 32'd0);
    step();
    chk("write_done_pulse", 32'({IRB_RW, done, busy}), 32'b111);
    step();
    chk("write_back_idle", 32'({IRB_RW, done, busy}), 32'b100);
  endtask

  task automatic issue(input int c, input bit strobe);
    wait_idle();
    cmd = 3'(c);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk($sformatf("accept_busy(cmd %0d)", c), 32'(busy), 32'd1);
    if (c == 0) begin
      do_write(strobe);
    end else begin
      apply_model(c);
      step();
      chk($sformatf("exec_one_cycle(cmd %0d)", c), 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int errs;
    bit exp_busy;
    int c;

    // Identity image: first load and plain dump.
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    #2;
    reset_and_load(1'b0);
    issue(0, 1'b0);

    // Average at (4,4): 27,28,35,36 -> 31.
    issue(5, 1'b0);
    issue(0, 1'b0);

    // Saturate to (1,1) then vertical flip of the corner window.
    for (int i = 0; i < 5; i++) issue(1, 1'b0);
    for (int i = 0; i < 5; i++) issue(3, 1'b0);
    issue(6, 1'b0);
    issue(0, 1'b0);

    // Back to (4,4), horizontal flip, then right to the x limit and average.
    for (int i = 0; i < 3; i++) issue(4, 1'b0);
    for (int i = 0; i < 3; i++) issue(2, 1'b0);
    issue(7, 1'b0);
    for (int i = 0; i < 4; i++) issue(4, 1'b0);
    issue(1, 1'b0);
    issue(1, 1'b0);
    issue(5, 1'b0);
    issue(0, 1'b1);
    issue(0, 1'b0);

    // cmd_valid held high: one command accepted per busy-low cycle.
    wait_idle();
    exp_busy = 1'b0;
    errs = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      c = $urandom_range(1, 7);
      cmd = 3'(c);
      step();
      if (!exp_busy) begin
        apply_model(c);
        exp_busy = 1'b1;
      end else begin
        exp_busy = 1'b0;
      end
      if (busy !== exp_busy) errs++;
    end
    cmd_valid = 1'b0;
    chk("held_valid_busy_pattern", 32'(errs), 32'd0);
    issue(0, 1'b0);

    // Random command stream against the model.
    for (int i = 0; i < 40; i++) begin
      c = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 7);
      issue(c, 1'($urandom_range(0, 1)));
    end
    issue(0, 1'b0);

    // Reset in the middle of load, reload random data.
    reset = 1'b1;
    step();
    reset = 1'b0;
    k = 0;
    while (!(IROM_EN === 1'b0 && IROM_A === 6'd30) && k < 100) begin step(); k++; end
    chk("reach_load_addr30", 32'(k < 100), 32'd1);
    reset_and_load(1'b1);
    issue(0, 1'b0);

    // Reset in the middle of a write, reload and keep going.
    wait_idle();
    cmd = 3'd0;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    k = 0;
    while (!(IRB_RW === 1'b0 && IRB_A === 6'd40) && k < 100) begin step(); k++; end
    chk("reach_write_addr40", 32'(k < 100), 32'd1);
    reset_and_load(1'b1);
    for (int i = 0; i < 10; i++) issue($urandom_range(1, 7), 1'b0);
    issue(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
